// File: rtl/reg_xfer_seq_pkg.sv
// Shared encodings for the register-transfer sequencer.
// Op codes, FSM states and the fixed PC register index.
`ifndef REG_XFER_SEQ_PKG_SV
`define REG_XFER_SEQ_PKG_SV

package reg_xfer_seq_pkg;

    typedef enum logic [1:0] {
        OP_MOV   = 2'b00,
        OP_SWAP  = 2'b01,
        OP_PCINC = 2'b10,
        OP_PCCLR = 2'b11
    } opE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MOV  = 3'd1,
        SW1  = 3'd2,
        SW2  = 3'd3,
        SW3  = 3'd4,
        INC  = 3'd5,
        CLR  = 3'd6,
        DONE = 3'd7
    } stateE;

    localparam logic [2:0] PC_IDX = 3'd7;

    typedef struct packed {
        opE         op;
        logic [2:0] src;
        logic [2:0] dst;
        logic       incAfter;
        logic       err;
    } reqT;

    // A swap through the scratch register cannot involve the scratch itself.
    function automatic logic swapIllegal(
        input logic [2:0] s,
        input logic [2:0] d,
        input logic [2:0] scr
    );
        return (s == d) || (s == scr) || (d == scr);
    endfunction

endpackage

`endif

// File: rtl/reg_xfer_seq_onehot_n3to8.sv
// 3-bit index plus enable to 8-bit active-low one-hot.
module onehot_n3to8 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] oneHotN
);

    always_comb begin
        oneHotN = 8'hFF;
        if (en) begin
            oneHotN[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/reg_xfer_seq.sv
// Moore sequencer driving register bus strobes for MOV/SWAP/PCINC/PCCLR.
// Outputs decode only from the state register and the latched request.
module reg_xfer_seq #(
    parameter int unsigned SCRATCH = 6
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] src,
    input  logic [2:0] dst,
    input  logic       incAfter,
    output logic [7:0] notOE,
    output logic [7:0] notLoad,
    output logic       pcInc,
    output logic       pcNotReset,
    output logic       aluPass,
    output logic       busy,
    output logic       done,
    output logic       err
);

    import reg_xfer_seq_pkg::*;

    localparam logic [2:0] SCR = 3'(SCRATCH);

    stateE state;
    stateE stateNext;
    reqT   req;
    logic  reqErr;

    logic [2:0] oeIdx;
    logic [2:0] ldIdx;
    logic       oeEn;
    logic       ldEn;

    assign reqErr = (opE'(op) == OP_SWAP) && swapIllegal(src, dst, SCR);

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state <= IDLE;
            req   <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && start) begin
                req <= '{op: opE'(op), src: src, dst: dst,
                         incAfter: incAfter, err: reqErr};
            end
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    unique case (opE'(op))
                        OP_MOV:   stateNext = MOV;
                        OP_SWAP:  stateNext = reqErr ? DONE : SW1;
                        OP_PCINC: stateNext = INC;
                        OP_PCCLR: stateNext = CLR;
                        default:  stateNext = IDLE;
                    endcase
                end
            end
            MOV:     stateNext = req.incAfter ? INC : DONE;
            SW1:     stateNext = SW2;
            SW2:     stateNext = SW3;
            SW3:     stateNext = req.incAfter ? INC : DONE;
            INC:     stateNext = DONE;
            CLR:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        oeIdx      = '0;
        ldIdx      = '0;
        oeEn       = 1'b0;
        ldEn       = 1'b0;
        pcInc      = 1'b0;
        pcNotReset = 1'b1;
        aluPass    = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        err        = (state == DONE) && req.err;
        unique case (state)
            MOV: begin
                // src==dst degenerates to an idle bus cycle.
                oeIdx   = req.src;
                ldIdx   = req.dst;
                oeEn    = (req.src != req.dst);
                ldEn    = (req.src != req.dst);
                aluPass = (req.src != req.dst);
            end
            SW1: begin
                oeIdx   = req.src;
                ldIdx   = SCR;
                oeEn    = 1'b1;
                ldEn    = 1'b1;
                aluPass = 1'b1;
            end
            SW2: begin
                oeIdx   = req.dst;
                ldIdx   = req.src;
                oeEn    = 1'b1;
                ldEn    = 1'b1;
                aluPass = 1'b1;
            end
            SW3: begin
                oeIdx   = SCR;
                ldIdx   = req.dst;
                oeEn    = 1'b1;
                ldEn    = 1'b1;
                aluPass = 1'b1;
            end
            INC:     pcInc = 1'b1;
            CLR:     pcNotReset = 1'b0;
            default: ;
        endcase
    end

    onehot_n3to8 uOe (
        .idx     (oeIdx),
        .en      (oeEn),
        .oneHotN (notOE)
    );

    onehot_n3to8 uLd (
        .idx     (ldIdx),
        .en      (ldEn),
        .oneHotN (notLoad)
    );

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Randomized bench for reg_xfer_seq against a cycle-list and register-file model.
module tb_reg_xfer_seq;

    logic       clock;
    logic       notReset;
    logic       start;
    logic [1:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic       incAfter;
    logic [7:0] notOE;
    logic [7:0] notLoad;
    logic       pcInc;
    logic       pcNotReset;
    logic       aluPass;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int failures = 0;

    localparam int SCR = 6;
    localparam logic [21:0] IDLE_VEC = {8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [7:0]  regs [8];
    logic [21:0] expQ [$];

    reg_xfer_seq #(.SCRATCH(SCR)) dut (
        .clock      (clock),
        .notReset   (notReset),
        .start      (start),
        .op         (op),
        .src        (src),
        .dst        (dst),
        .incAfter   (incAfter),
        .notOE      (notOE),
        .notLoad    (notLoad),
        .pcInc      (pcInc),
        .pcNotReset (pcNotReset),
        .aluPass    (aluPass),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [21:0] dutVec();
        return {notOE, notLoad, pcInc, pcNotReset, aluPass, busy, done, err};
    endfunction

    function automatic logic [2:0] lowIdx(input logic [7:0] v);
        for (int k = 0; k < 8; k++) if (!v[k]) return 3'(k);
        return 3'd0;
    endfunction

    // Register file driven by the bus strobes the DUT emits.
    always @(posedge clock) begin
        if (notReset) begin
            if (aluPass) regs[lowIdx(notLoad)] <= regs[lowIdx(notOE)];
            if (!pcNotReset) regs[7] <= 8'd0;
            else if (pcInc) regs[7] <= regs[7] + 8'd1;
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] cyc(
        input int oi, input int li, input logic inc, input logic clr,
        input logic dn, input logic er
    );
        logic [7:0] a;
        logic [7:0] b;
        a = 8'hFF;
        b = 8'hFF;
        if (oi >= 0) a[oi] = 1'b0;
        if (li >= 0) b[li] = 1'b0;
        return {a, b, inc, ~clr, (oi >= 0), 1'b1, dn, er};
    endfunction

    task automatic buildExp(input int o, input int s, input int d, input bit inc);
        bit bad;
        expQ.delete();
        bad = (s == d) || (s == SCR) || (d == SCR);
        if (o == 2) expQ.push_back(cyc(-1, -1, 1, 0, 0, 0));
        if (o == 3) expQ.push_back(cyc(-1, -1, 0, 1, 0, 0));
        if (o == 0) begin
            if (s == d) expQ.push_back(cyc(-1, -1, 0, 0, 0, 0));
            else expQ.push_back(cyc(s, d, 0, 0, 0, 0));
        end
        if (o == 1 && !bad) begin
            expQ.push_back(cyc(s, SCR, 0, 0, 0, 0));
            expQ.push_back(cyc(d, s, 0, 0, 0, 0));
            expQ.push_back(cyc(SCR, d, 0, 0, 0, 0));
        end
        if (inc && (o == 0 || (o == 1 && !bad))) expQ.push_back(cyc(-1, -1, 1, 0, 0, 0));
        expQ.push_back(cyc(-1, -1, 0, 0, 1, (o == 1) && bad));
    endtask

    // Called at a negedge with the DUT idle.
    task automatic runOp(input int o, input int s, input int d, input bit inc,
                         input string tag, input bit jitter);
        logic [7:0] snap [8];
        logic [7:0] e [8];
        bit bad;
        snap = regs;
        e = regs;
        bad = (s == d) || (s == SCR) || (d == SCR);
        start = 1'b1;
        op = 2'(o);
        src = 3'(s);
        dst = 3'(d);
        incAfter = inc;
        buildExp(o, s, d, inc);
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clock);
            checkEq($sformatf("%s.c%0d", tag, i), 64'(dutVec()), 64'(expQ[i]));
            if (jitter && i < expQ.size() - 1) begin
                start = 1'($urandom);
                op = 2'($urandom);
                src = 3'($urandom);
                dst = 3'($urandom);
                incAfter = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clock);
        checkEq({tag, ".idle"}, 64'(dutVec()), 64'(IDLE_VEC));
        if (o == 0) e[d] = snap[s];
        if (o == 1 && !bad) begin
            e[SCR] = snap[s];
            e[s] = snap[d];
            e[d] = snap[s];
        end
        if (inc && (o == 0 || (o == 1 && !bad))) e[7] = e[7] + 8'd1;
        if (o == 2) e[7] = e[7] + 8'd1;
        if (o == 3) e[7] = 8'd0;
        checkEq({tag, ".regs"},
                {regs[7], regs[6], regs[5], regs[4], regs[3], regs[2], regs[1], regs[0]},
                {e[7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]});
    endtask

    initial begin
        int lowCnt;
        notReset = 1'b0;
        start = 1'b0;
        op = '0;
        src = '0;
        dst = '0;
        incAfter = 1'b0;
        for (int k = 0; k < 8; k++) regs[k] = 8'($urandom);
        #1;
        checkEq("reset.async", 64'(dutVec()), 64'(IDLE_VEC));
        repeat (2) @(negedge clock);
        checkEq("reset.held", 64'(dutVec()), 64'(IDLE_VEC));
        notReset = 1'b1;

        runOp(0, 2, 5, 0, "mov2to5", 0);
        runOp(1, 1, 3, 0, "swap1_3", 0);
        runOp(1, 6, 2, 1, "swapBad", 0);
        runOp(0, 7, 0, 1, "movPcInc", 0);
        runOp(0, 4, 4, 1, "movNoop", 0);
        runOp(2, 3, 1, 1, "pcinc", 0);

        // Reset pulled during SW2 abandons the swap.
        start = 1'b1;
        op = 2'd1;
        src = 3'd1;
        dst = 3'd3;
        incAfter = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checkEq("rst.sw2", 64'(dutVec()), 64'(cyc(3, 1, 0, 0, 0, 0)));
        #2 notReset = 1'b0;
        #1;
        checkEq("rst.async", 64'(dutVec()), 64'(IDLE_VEC));
        @(negedge clock);
        checkEq("rst.nodone", 64'(dutVec()), 64'(IDLE_VEC));
        notReset = 1'b1;
        runOp(0, 0, 4, 0, "postRst", 0);

        // start held high through PCCLR.
        lowCnt = 0;
        start = 1'b1;
        op = 2'd3;
        @(negedge clock);
        if (!pcNotReset) lowCnt++;
        checkEq("hold.clr", 64'(dutVec()), 64'(cyc(-1, -1, 0, 1, 0, 0)));
        @(negedge clock);
        if (!pcNotReset) lowCnt++;
        checkEq("hold.done", 64'(dutVec()), 64'(cyc(-1, -1, 0, 0, 1, 0)));
        checkEq("hold.clrOnce", 64'(lowCnt), 64'd1);
        @(negedge clock);
        checkEq("hold.idle", 64'(dutVec()), 64'(IDLE_VEC));
        @(negedge clock);
        start = 1'b0;
        checkEq("hold.reacc", 64'(dutVec()), 64'(cyc(-1, -1, 0, 1, 0, 0)));
        @(negedge clock);
        checkEq("hold.done2", 64'(dutVec()), 64'(cyc(-1, -1, 0, 0, 1, 0)));
        @(negedge clock);
        checkEq("hold.idle2", 64'(dutVec()), 64'(IDLE_VEC));

        for (int n = 0; n < 60; n++) begin
            runOp(int'($urandom_range(3)), int'($urandom_range(7)),
                  int'($urandom_range(7)), 1'($urandom),
                  $sformatf("rnd%0d", n), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/reg_xfer_seq.md
REG_XFER_SEQ -- requirements
Module: reg_xfer_seq

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: notReset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  request pulse, sampled only in IDLE.
REQ-004 SHALL have ports: op  in  2  operation: 00 MOV, 01 SWAP, 10 PCINC, 11 PCCLR.
REQ-005 SHALL have ports: src  in  3  source register index (7 = PC).
REQ-006 SHALL have ports: dst  in  3  destination register index (7 = PC).
REQ-007 SHALL have ports: incAfter  in  1  append one PC-increment cycle after MOV/SWAP.
REQ-008 SHALL have ports: notOE  out  8  active-low per-register aBus output enable, at most one bit low.
REQ-009 SHALL have ports: notLoad  out  8  active-low per-register load from yBus, at most one bit low.
REQ-010 SHALL have ports: pcInc  out  1  PC increment enable.
REQ-011 SHALL have ports: pcNotReset  out  1  active-low PC clear.
REQ-012 SHALL have ports: aluPass  out  1  high when the ALU is to pass aBus to yBus.
REQ-013 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-014 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-015 SHALL have ports: err  out  1  qualifies done: illegal request rejected.
REQ-016 SHALL have one parameter: SCRATCH, default 6, the scratch register index used by SWAP.

Function
REQ-017 SHALL be a Moore FSM; outputs decode from registered state and latched operands only.
REQ-018 SHALL have states: IDLE, MOV, SW1, SW2, SW3, INC, CLR, DONE.
REQ-019 SHALL latch op, src, dst and incAfter on the edge where start=1 in IDLE; start in any other state SHALL be ignored.
REQ-020 SHALL sequence MOV: notOE[src]=0, notLoad[dst]=0, aluPass=1 for one cycle.
REQ-021 SHALL sequence SWAP: SW1 SCRATCH<=src, SW2 src<=dst, SW3 dst<=SCRATCH; each is one cycle with one notOE bit low, one notLoad bit low and aluPass=1.
REQ-022 SHALL drive INC as pcInc=1 for one cycle, with all notOE/notLoad bits high.
REQ-023 SHALL drive CLR as pcNotReset=0 for one cycle.
REQ-024 SHALL advance from the last MOV/SWAP cycle to INC when incAfter=1, else to DONE; INC and CLR SHALL advance to DONE.
REQ-025 SHALL, in DONE, assert done=1 and busy=1 for one cycle, then return to IDLE.
REQ-026 SHALL give latency from start edge to done cycle as: MOV 2, SWAP 4, PCINC 2, PCCLR 2, plus 1 when incAfter applies.
REQ-027 SHALL treat MOV with src==dst as a no-op: one cycle with all notOE/notLoad bits high, then normal completion, err=0.
REQ-028 SHALL reject SWAP with src==dst, src==SCRATCH or dst==SCRATCH: go directly to DONE with err=1, no bus activity, incAfter ignored.
REQ-029 SHALL ignore src, dst and incAfter for PCINC/PCCLR.
REQ-030 SHALL hold err=0 whenever done=0.
REQ-031 SHALL, in IDLE, drive notOE=8'hFF, notLoad=8'hFF, pcInc=0, pcNotReset=1, aluPass=0.

Reset
REQ-032 SHALL, while notReset=0, immediately (asynchronously) force state IDLE and the REQ-031 output values, with busy=0, done=0, err=0.
REQ-033 SHALL, when reset occurs mid-SWAP, abandon the operation with no further bus cycles; the partial register contents are the requester's concern.
REQ-034 SHALL accept start on the first rising edge after notReset deasserts.

Structure
REQ-035 SHALL place the op encodings, state encodings and PC index 7 in a shared package/include with an include guard.
REQ-036 SHALL instantiate one sub-module, onehot_n3to8, converting a 3-bit index plus enable into an 8-bit active-low one-hot; it is used for both notOE and notLoad.

Verification
REQ-037 SHALL cover MOV src=2 dst=5 incAfter=0: next cycle notOE=8'hFB, notLoad=8'hDF, aluPass=1; done the following cycle with err=0.
REQ-038 SHALL cover SWAP src=1 dst=3: (notOE,notLoad) = (FD,BF), (F7,FD), (BF,F7) on three consecutive cycles; then done; r1 and r3 contents exchanged.
REQ-039 SHALL cover SWAP src=6 dst=2: done in the cycle after start with err=1; notOE/notLoad stay 8'hFF throughout.
REQ-040 SHALL cover MOV src=7 dst=0 incAfter=1: notOE=8'h7F, notLoad=8'hFE; then pcInc=1 for one cycle; then done (latency 3).
REQ-041 SHALL cover notReset pulled low during SW2: outputs return to IDLE values within the same cycle, busy=0, and no done pulse occurs.
REQ-042 SHALL cover start held high through a PCCLR: pcNotReset=0 for exactly one cycle; start is re-accepted only after DONE.
